// File: rtl/inst_fetch_if.sv
// Fetch-side bus: ROM address/data, redirect request and the decode-stage valid/ready stream.
// master is the fetch controller, slave is the ROM/decode environment around it.
interface inst_fetch_if;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;

  modport master (
    output mem_addr,
    output out_valid,
    output out_inst,
    output out_pc,
    input  mem_data,
    input  redirect_valid,
    input  redirect_pc,
    input  out_ready
  );

  modport slave (
    input  mem_addr,
    input  out_valid,
    input  out_inst,
    input  out_pc,
    output mem_data,
    output redirect_valid,
    output redirect_pc,
    output out_ready
  );
endinterface

// File: rtl/inst_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, issues one ROM read per cycle and buffers returned
// words in a 2-entry FIFO towards decode. Redirects flush buffered and in-flight words.
module inst_fetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned ADDR_WIDTH = 8
) (
  input logic               clock,
  input logic               reset,
  inst_fetch_if.master      bus_io
);

  logic [31:0] pc_q, pc_d;
  logic        inflight_q, inflight_d;
  logic [31:0] inflight_pc_q, inflight_pc_d;
  logic [1:0]  count_q, count_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic [31:0] fifo_pc_q   [2];
  logic [31:0] fifo_inst_q [2];

  logic        out_valid;
  logic        pop;
  logic        push;
  logic        issue;
  logic        wr_ptr;
  logic [2:0]  occupancy;
  logic [31:0] redirect_tgt;
  logic [31:0] mem_addr;

  // ROM aliasing above its size is handled by the ROM itself; the width is informational here.
  logic [31:0] unused_addr_width;
  logic [1:0]  unused_redirect_lsbs;
  assign unused_addr_width    = ADDR_WIDTH;
  assign unused_redirect_lsbs = bus_io.redirect_pc[1:0];

  assign redirect_tgt = {bus_io.redirect_pc[31:2], 2'b00};

  always_comb begin
    out_valid = !reset && (count_q != 2'd0);
    pop       = out_valid && bus_io.out_ready;
    occupancy = {1'b0, count_q} - {2'b00, pop} + {2'b00, inflight_q};
    issue     = (occupancy < 3'd2);
    push      = inflight_q && !bus_io.redirect_valid;
    // A push only happens with count <= 1, so the slot after the head is always free.
    wr_ptr    = rd_ptr_q ^ count_q[0];

    if (reset) begin
      mem_addr = RESET_PC;
    end else if (bus_io.redirect_valid) begin
      mem_addr = redirect_tgt;
    end else begin
      mem_addr = pc_q;
    end
  end

  always_comb begin
    pc_d          = pc_q;
    inflight_d    = inflight_q;
    inflight_pc_d = inflight_pc_q;
    count_d       = count_q;
    rd_ptr_d      = rd_ptr_q;

    if (bus_io.redirect_valid) begin
      pc_d          = redirect_tgt + 32'd4;
      inflight_d    = 1'b1;
      inflight_pc_d = redirect_tgt;
      count_d       = 2'd0;
      rd_ptr_d      = 1'b0;
    end else begin
      count_d  = count_q - {1'b0, pop} + {1'b0, push};
      rd_ptr_d = rd_ptr_q ^ pop;
      if (issue) begin
        pc_d          = pc_q + 32'd4;
        inflight_d    = 1'b1;
        inflight_pc_d = pc_q;
      end else begin
        inflight_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= RESET_PC;
      count_q       <= 2'd0;
      rd_ptr_q      <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      count_q       <= count_d;
      rd_ptr_q      <= rd_ptr_d;
      if (push) begin
        fifo_pc_q[wr_ptr]   <= inflight_pc_q;
        fifo_inst_q[wr_ptr] <= bus_io.mem_data;
      end
    end
  end

  assign bus_io.mem_addr  = mem_addr;
  assign bus_io.out_valid = out_valid;
  assign bus_io.out_inst  = reset ? 32'd0 : fifo_inst_q[rd_ptr_q];
  assign bus_io.out_pc    = reset ? 32'd0 : fifo_pc_q[rd_ptr_q];

endmodule

// File: doc/inst_fetch_ctrl.md
# inst_fetch_ctrl

Instruction-fetch sequencer for the simple processor's single-port instruction ROM. It owns the program counter and issues one word fetch per cycle to the ROM, which has a one-cycle registered read. Returned words are buffered in a 2-entry skid FIFO and presented to the decode stage through a valid/ready handshake. Branch and jump redirects flush all buffered and in-flight words.

## Interface
- RESET_PC, 32'h00000000, byte address of the first fetch after reset.
- ADDR_WIDTH, 8, ROM word-address width. Addresses above the ROM size alias in the ROM; this block does not check them.
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- mem_addr  out  32  byte address to the ROM; combinational; bits [1:0] always 0.
- mem_data  in  32  ROM read data; valid the cycle after the matching mem_addr.
- redirect_valid  in  1  single-cycle pulse: discard the fetch stream and restart at redirect_pc.
- redirect_pc  in  32  new fetch target; bits [1:0] are ignored and treated as 0.
- out_valid  out  1  out_inst and out_pc hold a valid instruction (FIFO head).
- out_ready  in  1  the consumer accepts the head this cycle.
- out_inst  out  32  instruction word.
- out_pc  out  32  byte address the instruction was fetched from.

## Operation
**State**
- pc (32 bits): next sequential fetch address.
- inflight (1 bit) and inflight_pc (32 bits): a fetch was issued last cycle, so mem_data is valid this cycle.
- FIFO: 2 entries of {pc, inst}, with count in the range 0..2.

**Handshake**
- pop = out_valid & out_ready.
- out_valid = (count != 0). The FIFO head drives out_inst and out_pc.
- A word returned from the ROM always enters the FIFO first; there is no bypass.

**Issue rule (no redirect)**
- issue = (count − pop + inflight) < 2.
- When issue = 1: mem_addr = pc, pc ← pc + 4, inflight ← 1, inflight_pc ← pc.
- When issue = 0: mem_addr = pc (its result is ignored), inflight ← 0, pc holds.

**Write rule**
- When inflight = 1 and redirect_valid = 0, {inflight_pc, mem_data} is pushed to the FIFO at the end of the cycle.
- count_next = count − pop + push. count never exceeds 2; this must be asserted in the bench.

**Redirect (priority over all else)**
- A pop in the same cycle still completes.
- All remaining FIFO entries are flushed (count ← 0).
- The mem_data of the current in-flight fetch is dropped.
- mem_addr = {redirect_pc[31:2], 2'b00} and is issued that cycle. pc ← that address + 4, inflight ← 1, inflight_pc ← that address.

**Arithmetic**
- pc + 4 wraps modulo 2^32 with no flag.

**Reset**
- pc ← RESET_PC, inflight ← 0, count ← 0.
- During reset: out_valid = 0, out_inst = 0, out_pc = 0, mem_addr = RESET_PC.
- Reset in mid-stream discards everything; no word fetched before reset is ever presented afterwards.

## Timing
- Fetch latency: a fetch issued in cycle T returns on mem_data in T+1, enters the FIFO at the end of T+1, and is visible on out_valid in T+2.
- After reset deasserts in cycle 0, the first issue of RESET_PC is in cycle 0 and out_valid first rises in cycle 2.
- Throughput: one instruction per cycle while out_ready is held high. Steady state is count = 1, inflight = 1, and an issue every cycle.
- Stall: when out_ready is low, the FIFO fills to 2 and issue stops. No word is lost or duplicated. Fetching resumes in the same cycle out_ready rises.
- Redirect in cycle T: out_valid = 0 in T+1, and the instruction at redirect_pc appears in T+2.
- Back-to-back redirects: each pulse overrides the previous one. Only the last redirect's stream is ever presented.

## Test plan
- **Reset and sequential fetch.** RESET_PC = 0, ROM word i = i, out_ready = 1. Required: out_valid first rises in cycle 2, then pc/inst pairs 0/0, 4/1, 8/2, … arrive one per cycle with no gaps.
- **Stall.** Drop out_ready for 5 cycles in mid-stream. Required: count saturates at 2, the head stays constant, and after release the sequence continues with no skipped or repeated pc.
- **Redirect while full.** out_ready = 0 with count = 2, then redirect to 0x40. Required: both buffered words vanish, and the next presented word is out_pc = 0x40, out_inst = ROM[16], exactly 2 cycles later.
- **Redirect with pop.** Redirect to 0x23 in a cycle where the head is accepted. Required: the head transfers, the address 0x20 is fetched, and no word issued before the redirect appears afterwards.
- **Reset mid-stream.** Assert reset while count = 2 and inflight = 1. Required: out_valid = 0 and out_inst = 0 throughout reset; afterwards the stream restarts at RESET_PC.
- **Wrap.** Redirect to 0xFFFFFFFC. Required: presented pcs are 0xFFFFFFFC, then 0x00000000, then 0x00000004.
